// File: rtl/prt_riscv_cpu_wb.sv
// prt_riscv_cpu_wb: RISC-V writeback stage. It formats load data, arbitrates load and ALU results
//   onto the single register-file write port, and tracks the one outstanding load for stall/forwarding.
// Latency: ALU accept or LD_VLD_IN in cycle n gives RD_* in cycle n+1. An ALU result that collides
//   with a load response is skidded and written at n+2 or later.
// Backpressure: ALU_RDY_OUT drops while the skid register is full or the ALU would overwrite the
//   pending load's destination. LD_REQ_RDY_OUT drops while a load is outstanding.
// Ports: CLK_IN/RST_IN (async active-low); ALU_* result channel; LD_REQ_* load issue; LD_DAT_IN/LD_VLD_IN
//   load response; RS1/RS2_IDX_IN decode sources; STALL_OUT, RSx_FWD_OUT, FWD_DAT_OUT hazard outputs;
//   RD_IDX_OUT/RD_DAT_OUT/RD_WR_OUT register-file write port.
module prt_riscv_cpu_wb #(
  parameter int P_IDX = 4
) (
  input  logic             CLK_IN,
  input  logic             RST_IN,
  input  logic [P_IDX-1:0] ALU_IDX_IN,
  input  logic [31:0]      ALU_DAT_IN,
  input  logic             ALU_VLD_IN,
  output logic             ALU_RDY_OUT,
  input  logic             LD_REQ_IN,
  input  logic [P_IDX-1:0] LD_REQ_IDX_IN,
  input  logic [2:0]       LD_REQ_F3_IN,
  input  logic [1:0]       LD_REQ_LSB_IN,
  output logic             LD_REQ_RDY_OUT,
  input  logic [31:0]      LD_DAT_IN,
  input  logic             LD_VLD_IN,
  input  logic [P_IDX-1:0] RS1_IDX_IN,
  input  logic [P_IDX-1:0] RS2_IDX_IN,
  output logic             STALL_OUT,
  output logic             RS1_FWD_OUT,
  output logic             RS2_FWD_OUT,
  output logic [31:0]      FWD_DAT_OUT,
  output logic [P_IDX-1:0] RD_IDX_OUT,
  output logic [31:0]      RD_DAT_OUT,
  output logic             RD_WR_OUT
);

  // Outstanding load
  logic             pending;
  logic [P_IDX-1:0] ld_idx;
  logic [2:0]       ld_f3;
  logic [1:0]       ld_lsb;

  // One-entry skid for an ALU result displaced by a load response
  logic             skid_full;
  logic [P_IDX-1:0] skid_idx;
  logic [31:0]      skid_dat;

  // Registered write port
  logic             rd_wr;
  logic [P_IDX-1:0] rd_idx;
  logic [31:0]      rd_dat;

  logic             ld_resp;
  logic             ld_acc;
  logic             alu_acc;
  logic             alu_waw;
  logic             ld_hit;
  logic             skid_hit;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [31:0]      ld_fmt;

  // A response with no load outstanding is stray and dropped
  assign ld_resp = LD_VLD_IN && pending;
  assign ld_acc  = LD_REQ_IN && !pending;

  // The ALU must not retire to the pending load's destination ahead of the older load
  assign alu_waw = pending && (ALU_IDX_IN == ld_idx) && (ld_idx != '0);

  assign ALU_RDY_OUT    = !skid_full && !alu_waw;
  assign alu_acc        = ALU_VLD_IN && ALU_RDY_OUT;
  assign LD_REQ_RDY_OUT = !pending;

  // Pending stays set through the response cycle, so the stall covers that cycle as well.
  // Forwarding then takes over in the write cycle.
  assign ld_hit   = pending && (ld_idx != '0) &&
                    ((RS1_IDX_IN == ld_idx) || (RS2_IDX_IN == ld_idx));
  assign skid_hit = skid_full && (skid_idx != '0) &&
                    ((RS1_IDX_IN == skid_idx) || (RS2_IDX_IN == skid_idx));
  assign STALL_OUT = ld_hit || skid_hit;

  // The register file returns pre-write data in its write cycle, so bypass it
  assign RS1_FWD_OUT = rd_wr && (rd_idx == RS1_IDX_IN) && (RS1_IDX_IN != '0);
  assign RS2_FWD_OUT = rd_wr && (rd_idx == RS2_IDX_IN) && (RS2_IDX_IN != '0);
  assign FWD_DAT_OUT = rd_dat;

  assign RD_WR_OUT  = rd_wr;
  assign RD_IDX_OUT = rd_idx;
  assign RD_DAT_OUT = rd_dat;

  // Load formatting. The lane is selected by the address bits latched at issue.
  always_comb begin
    ld_byte = LD_DAT_IN[7:0];
    case (ld_lsb)
      2'd0:    ld_byte = LD_DAT_IN[7:0];
      2'd1:    ld_byte = LD_DAT_IN[15:8];
      2'd2:    ld_byte = LD_DAT_IN[23:16];
      default: ld_byte = LD_DAT_IN[31:24];
    endcase
    ld_half = ld_lsb[1] ? LD_DAT_IN[31:16] : LD_DAT_IN[15:0];
    case (ld_f3)
      3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_fmt = {24'd0, ld_byte};
      3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_fmt = {16'd0, ld_half};
      default: ld_fmt = LD_DAT_IN;
    endcase
  end

  always_ff @(posedge CLK_IN or negedge RST_IN) begin
    if (!RST_IN) begin
      pending   <= 1'b0;
      ld_idx    <= '0;
      ld_f3     <= '0;
      ld_lsb    <= '0;
      skid_full <= 1'b0;
      skid_idx  <= '0;
      skid_dat  <= '0;
      rd_wr     <= 1'b0;
      rd_idx    <= '0;
      rd_dat    <= '0;
    end else begin
      // Accept and response are exclusive because accept requires !pending
      if (ld_acc) begin
        pending <= 1'b1;
        ld_idx  <= LD_REQ_IDX_IN;
        ld_f3   <= LD_REQ_F3_IN;
        ld_lsb  <= LD_REQ_LSB_IN;
      end else if (ld_resp) begin
        pending <= 1'b0;
      end

      // Priority: load response, then skid entry, then a fresh ALU result.
      // Index 0 is consumed but never strobed.
      rd_wr <= 1'b0;
      if (ld_resp) begin
        rd_wr  <= (ld_idx != '0);
        rd_idx <= ld_idx;
        rd_dat <= ld_fmt;
        if (alu_acc) begin
          skid_full <= 1'b1;
          skid_idx  <= ALU_IDX_IN;
          skid_dat  <= ALU_DAT_IN;
        end
      end else if (skid_full) begin
        // alu_acc is impossible here because ALU_RDY_OUT is low while the skid register is full
        rd_wr     <= (skid_idx != '0);
        rd_idx    <= skid_idx;
        rd_dat    <= skid_dat;
        skid_full <= 1'b0;
      end else if (alu_acc) begin
        rd_wr  <= (ALU_IDX_IN != '0);
        rd_idx <= ALU_IDX_IN;
        rd_dat <= ALU_DAT_IN;
      end
    end
  end

endmodule

// File: tb/tb_prt_riscv_cpu_wb.sv
// Testbench for prt_riscv_cpu_wb. It applies a table of load-format vectors, hand sequences for
// collisions, hazards and reset, then randomized traffic. Every cycle is checked against a
// transaction-level reference model.
module tb_prt_riscv_cpu_wb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  alu_idx = '0;
  logic [31:0] alu_dat = '0;
  logic        alu_vld = 1'b0;
  logic        alu_rdy;
  logic        ld_req = 1'b0;
  logic [3:0]  ld_req_idx = '0;
  logic [2:0]  ld_req_f3 = '0;
  logic [1:0]  ld_req_lsb = '0;
  logic        ld_req_rdy;
  logic [31:0] ld_dat = '0;
  logic        ld_vld = 1'b0;
  logic [3:0]  rs1 = '0;
  logic [3:0]  rs2 = '0;
  logic        stall, fwd1, fwd2;
  logic [31:0] fwd_dat;
  logic [3:0]  rd_idx;
  logic [31:0] rd_dat;
  logic        rd_wr;

  always #5 clk = ~clk;

  prt_riscv_cpu_wb #(.P_IDX(4)) dut (
    .CLK_IN(clk), .RST_IN(rst_n),
    .ALU_IDX_IN(alu_idx), .ALU_DAT_IN(alu_dat), .ALU_VLD_IN(alu_vld), .ALU_RDY_OUT(alu_rdy),
    .LD_REQ_IN(ld_req), .LD_REQ_IDX_IN(ld_req_idx), .LD_REQ_F3_IN(ld_req_f3),
    .LD_REQ_LSB_IN(ld_req_lsb), .LD_REQ_RDY_OUT(ld_req_rdy),
    .LD_DAT_IN(ld_dat), .LD_VLD_IN(ld_vld),
    .RS1_IDX_IN(rs1), .RS2_IDX_IN(rs2),
    .STALL_OUT(stall), .RS1_FWD_OUT(fwd1), .RS2_FWD_OUT(fwd2), .FWD_DAT_OUT(fwd_dat),
    .RD_IDX_OUT(rd_idx), .RD_DAT_OUT(rd_dat), .RD_WR_OUT(rd_wr)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  typedef struct {
    logic [3:0]  idx;
    logic [31:0] dat;
  } wr_t;

  wr_t         m_q[$];     // ALU results waiting behind a load response
  bit          m_pend;
  logic [3:0]  m_ld_idx;
  logic [2:0]  m_ld_f3;
  logic [1:0]  m_ld_lsb;
  bit          m_wr;
  logic [3:0]  m_idx;
  logic [31:0] m_dat;

  function automatic logic [31:0] ref_fmt(input logic [2:0] f3, input logic [1:0] lsb,
                                          input logic [31:0] w);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * lsb)) & 32'h0000_00FF;
    h = (w >> (16 * lsb[1])) & 32'h0000_FFFF;
    case (f3)
      3'b000:  return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      3'b100:  return b;
      3'b001:  return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_pend = 0; m_ld_idx = '0; m_ld_f3 = '0; m_ld_lsb = '0;
    m_wr = 0; m_idx = '0; m_dat = '0;
  endtask

  // One clock: check combinational outputs against the model, advance the model, then check RD_*
  task automatic tick();
    bit e_ardy, e_stall, e_f1, e_f2, resp, atake, ltake, took;
    logic [3:0]  nidx;
    logic [31:0] ndat;
    wr_t w;
    #2;
    e_ardy  = (m_q.size() == 0) && !(m_pend && alu_idx == m_ld_idx && m_ld_idx != 0);
    e_stall = (m_pend && m_ld_idx != 0 && (rs1 == m_ld_idx || rs2 == m_ld_idx)) ||
              (m_q.size() != 0 && m_q[0].idx != 0 && (rs1 == m_q[0].idx || rs2 == m_q[0].idx));
    e_f1 = m_wr && m_idx == rs1 && rs1 != 0;
    e_f2 = m_wr && m_idx == rs2 && rs2 != 0;
    check("alu_rdy", {31'd0, alu_rdy}, {31'd0, e_ardy});
    check("ld_req_rdy", {31'd0, ld_req_rdy}, {31'd0, !m_pend});
    check("stall", {31'd0, stall}, {31'd0, e_stall});
    check("rs1_fwd", {31'd0, fwd1}, {31'd0, e_f1});
    check("rs2_fwd", {31'd0, fwd2}, {31'd0, e_f2});
    if (m_wr) check("fwd_dat", fwd_dat, m_dat);

    resp  = ld_vld && m_pend;
    atake = alu_vld && e_ardy;
    ltake = ld_req && !m_pend;
    took  = 0;
    nidx  = '0;
    ndat  = '0;
    if (resp) begin
      nidx = m_ld_idx; ndat = ref_fmt(m_ld_f3, m_ld_lsb, ld_dat); took = 1;
      m_pend = 0;
      if (atake) m_q.push_back('{idx: alu_idx, dat: alu_dat});
    end else if (m_q.size() != 0) begin
      w = m_q.pop_front(); nidx = w.idx; ndat = w.dat; took = 1;
    end else if (atake) begin
      nidx = alu_idx; ndat = alu_dat; took = 1;
    end
    if (ltake) begin
      m_pend = 1; m_ld_idx = ld_req_idx; m_ld_f3 = ld_req_f3; m_ld_lsb = ld_req_lsb;
    end
    m_wr = took && nidx != 0;
    if (took) begin m_idx = nidx; m_dat = ndat; end

    @(posedge clk); #1;
    check("rd_wr", {31'd0, rd_wr}, {31'd0, m_wr});
    if (m_wr) begin
      check("rd_idx", {28'd0, rd_idx}, {28'd0, m_idx});
      check("rd_dat", rd_dat, m_dat);
    end
  endtask

  task automatic idle();
    alu_vld = 0; alu_idx = '0; alu_dat = '0;
    ld_req = 0; ld_req_idx = '0; ld_req_f3 = '0; ld_req_lsb = '0;
    ld_vld = 0; ld_dat = '0; rs1 = '0; rs2 = '0;
  endtask

  // Asynchronous reset asserted mid-cycle and released mid-cycle
  task automatic do_reset();
    rst_n = 0;
    model_reset();
    @(posedge clk); #3;
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic reset_state_checks(input string tag);
    #1;
    check({tag, "_rd_wr"}, {31'd0, rd_wr}, 32'd0);
    check({tag, "_rd_idx"}, {28'd0, rd_idx}, 32'd0);
    check({tag, "_rd_dat"}, rd_dat, 32'd0);
    check({tag, "_ld_req_rdy"}, {31'd0, ld_req_rdy}, 32'd1);
    check({tag, "_alu_rdy"}, {31'd0, alu_rdy}, 32'd1);
    check({tag, "_stall"}, {31'd0, stall}, 32'd0);
    check({tag, "_fwd"}, {30'd0, fwd1, fwd2}, 32'd0);
  endtask

  task automatic issue_load(input logic [3:0] idx, input logic [2:0] f3, input logic [1:0] lsb);
    idle();
    ld_req = 1; ld_req_idx = idx; ld_req_f3 = f3; ld_req_lsb = lsb;
    tick();
    idle();
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  lsb;
    logic [31:0] word;
    logic [31:0] exp;
  } fmt_vec_t;

  fmt_vec_t tbl[13];

  initial begin
    tbl[0]  = '{3'b000, 2'd3, 32'h80FF_FF00, 32'hFFFF_FF80};
    tbl[1]  = '{3'b100, 2'd3, 32'h80FF_FF00, 32'h0000_0080};
    tbl[2]  = '{3'b101, 2'd2, 32'h80FF_FF00, 32'h0000_80FF};
    tbl[3]  = '{3'b001, 2'd2, 32'h80FF_FF00, 32'hFFFF_80FF};
    tbl[4]  = '{3'b001, 2'd0, 32'h80FF_FF00, 32'hFFFF_FF00};
    tbl[5]  = '{3'b101, 2'd0, 32'h80FF_FF00, 32'h0000_FF00};
    tbl[6]  = '{3'b000, 2'd1, 32'h80FF_FF00, 32'hFFFF_FFFF};
    tbl[7]  = '{3'b100, 2'd0, 32'h80FF_FF00, 32'h0000_0000};
    tbl[8]  = '{3'b010, 2'd1, 32'h80FF_FF00, 32'h80FF_FF00};
    tbl[9]  = '{3'b011, 2'd2, 32'h1234_5678, 32'h1234_5678};
    tbl[10] = '{3'b110, 2'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    tbl[11] = '{3'b000, 2'd2, 32'h1234_5678, 32'h0000_0034};
    tbl[12] = '{3'b001, 2'd1, 32'h1234_8765, 32'hFFFF_8765};

    idle();
    model_reset();
    #2;
    reset_state_checks("reset");
    do_reset();
    reset_state_checks("post_reset");

    // ALU write idx 5, then forwarding in the write cycle
    idle();
    alu_vld = 1; alu_idx = 4'd5; alu_dat = 32'h1234_5678;
    tick();
    check("alu5_wr", {31'd0, rd_wr}, 32'd1);
    check("alu5_idx", {28'd0, rd_idx}, 32'd5);
    check("alu5_dat", rd_dat, 32'h1234_5678);
    idle();
    rs1 = 4'd5;
    #1 check("alu5_fwd1", {31'd0, fwd1}, 32'd1);
    tick();

    // Load format table
    for (int i = 0; i < 13; i++) begin
      issue_load(4'd7, tbl[i].f3, tbl[i].lsb);
      ld_vld = 1; ld_dat = tbl[i].word;
      tick();
      check($sformatf("fmt%0d_idx", i), {28'd0, rd_idx}, 32'd7);
      check($sformatf("fmt%0d_dat", i), rd_dat, tbl[i].exp);
      idle();
    end

    // Load-use stall on RS2, then forwarding in the write cycle
    issue_load(4'd3, 3'b010, 2'd0);
    rs2 = 4'd3;
    #1 check("lu_stall_pend", {31'd0, stall}, 32'd1);
    tick();
    ld_vld = 1; ld_dat = 32'h0000_0033;
    #1 check("lu_stall_resp", {31'd0, stall}, 32'd1);
    tick();
    ld_vld = 0;
    #1 check("lu_stall_after", {31'd0, stall}, 32'd0);
    check("lu_fwd2", {31'd0, fwd2}, 32'd1);
    tick();
    idle();

    // Collision: load response and ALU result in the same cycle
    issue_load(4'd2, 3'b010, 2'd0);
    ld_vld = 1; ld_dat = 32'h0000_0022;
    alu_vld = 1; alu_idx = 4'd4; alu_dat = 32'h0000_000A;
    tick();
    check("coll_ld_idx", {28'd0, rd_idx}, 32'd2);
    check("coll_ld_dat", rd_dat, 32'h22);
    idle();
    #1 check("coll_alu_rdy", {31'd0, alu_rdy}, 32'd0);
    tick();
    check("coll_alu_wr", {31'd0, rd_wr}, 32'd1);
    check("coll_alu_idx", {28'd0, rd_idx}, 32'd4);
    check("coll_alu_dat", rd_dat, 32'hA);

    // WAW: ALU to the pending load's destination waits for the load write
    issue_load(4'd6, 3'b010, 2'd0);
    alu_vld = 1; alu_idx = 4'd6; alu_dat = 32'h0000_0066;
    #1 check("waw_rdy0", {31'd0, alu_rdy}, 32'd0);
    tick();
    ld_vld = 1; ld_dat = 32'h0000_0600;
    #1 check("waw_rdy_resp", {31'd0, alu_rdy}, 32'd0);
    tick();
    check("waw_ld_dat", rd_dat, 32'h600);
    ld_vld = 0;
    #1 check("waw_rdy1", {31'd0, alu_rdy}, 32'd1);
    tick();
    check("waw_alu_idx", {28'd0, rd_idx}, 32'd6);
    check("waw_alu_dat", rd_dat, 32'h66);
    idle();

    // Write to x0 is consumed but not strobed
    alu_vld = 1; alu_idx = 4'd0; alu_dat = 32'h0000_0099;
    #1 check("x0_rdy", {31'd0, alu_rdy}, 32'd1);
    tick();
    check("x0_wr", {31'd0, rd_wr}, 32'd0);
    idle();

    // Reset with a load pending, then a late response
    issue_load(4'd9, 3'b010, 2'd0);
    do_reset();
    reset_state_checks("rst_pend");
    ld_vld = 1; ld_dat = 32'hCAFE_F00D;
    tick();
    check("late_vld_wr", {31'd0, rd_wr}, 32'd0);
    check("late_vld_ldrdy", {31'd0, ld_req_rdy}, 32'd1);
    idle();

    // Reset with the skid register full discards the entry
    issue_load(4'd2, 3'b010, 2'd0);
    ld_vld = 1; ld_dat = 32'h1;
    alu_vld = 1; alu_idx = 4'd8; alu_dat = 32'h88;
    tick();
    idle();
    do_reset();
    reset_state_checks("rst_skid");
    tick();
    check("skid_discard_wr", {31'd0, rd_wr}, 32'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      alu_vld    = ($urandom_range(0, 1) == 1);
      alu_idx    = 4'($urandom_range(0, 3));
      alu_dat    = $urandom;
      ld_req     = ($urandom_range(0, 2) == 0);
      ld_req_idx = 4'($urandom_range(0, 3));
      ld_req_f3  = 3'($urandom_range(0, 7));
      ld_req_lsb = 2'($urandom_range(0, 3));
      ld_vld     = ($urandom_range(0, 2) == 0);
      ld_dat     = $urandom;
      rs1        = 4'($urandom_range(0, 3));
      rs2        = 4'($urandom_range(0, 3));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
